// File: rtl/tlb_maint_unit.sv
// TLB array with a serialised maintenance engine and a combinational lookup port.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | ready for a maintenance request; req_ready high
// ST_SWEEP | INVTLB in progress, one entry per cycle at ptr
// ST_DONE  | one-cycle completion pulse on resp_valid
//
// Entry layout (89 bits): [88] e, [87:69] vppn, [68:63] ps, [62:53] asid,
// [52] g, [51:26] page0, [25:0] page1. The e bits live in their own
// resettable vector; the remaining 88 bits are unreset storage.
module tlb_maint_unit #(
    parameter int          TLBNUM    = 16,
    parameter int          IDX_W     = $clog2(TLBNUM),
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [4:0]       req_invop,
    input  logic [IDX_W-1:0] req_index,
    input  logic [9:0]       req_asid,
    input  logic [18:0]      req_vppn,
    input  logic [88:0]      req_entry,
    output logic             resp_valid,
    output logic             resp_err,
    output logic             resp_hit,
    output logic [IDX_W-1:0] resp_index,
    output logic [88:0]      resp_entry,
    input  logic [18:0]      lk_vppn,
    input  logic             lk_odd,
    input  logic [9:0]       lk_asid,
    output logic             lk_found,
    output logic [IDX_W-1:0] lk_index,
    output logic [5:0]       lk_ps,
    output logic [25:0]      lk_page
);

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_t;

    state_t            state, state_nxt;
    logic [TLBNUM-1:0] tlb_e;
    logic [87:0]       tlb_body [TLBNUM];
    logic [15:0]       lfsr;
    logic [IDX_W-1:0]  ptr;
    logic [2:0]        inv_op;
    logic [9:0]        inv_asid;
    logic [18:0]       inv_vppn;

    logic [TLBNUM-1:0] lk_match, srch_match;
    logic              lk_hit, srch_hit;
    logic [IDX_W-1:0]  lk_idx, srch_idx;
    logic              acc, is_inv, inv_bad, req_bad, start_sweep, sweep_last;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx, victim;
    logic [87:0]       sw_body;
    logic              sw_g, sw_asid_m, sw_va_m, sw_clear, lk_sel_odd;

    // Large pages (ps=21) only compare the upper 10 vppn bits.
    function automatic logic vppn_eq(input logic [18:0] ent_vppn, input logic [5:0] ps,
                                     input logic [18:0] vppn);
        if (ps == 6'd21) return ent_vppn[18:9] == vppn[18:9];
        return ent_vppn == vppn;
    endfunction

    assign victim      = lfsr[IDX_W-1:0];
    assign acc         = req_valid & req_ready;
    assign is_inv      = (req_op == OP_INV);
    assign inv_bad     = is_inv & (req_invop > 5'd6);
    assign req_bad     = (req_op > OP_INV) | inv_bad;
    assign start_sweep = acc & is_inv & ~inv_bad;
    assign sweep_last  = (ptr == IDX_W'(TLBNUM - 1));
    assign wr_en       = acc & ((req_op == OP_WR) | (req_op == OP_FILL));
    assign wr_idx      = (req_op == OP_FILL) ? victim : req_index;

    // Per-entry match vectors for the lookup port and for TLBSRCH.
    always_comb begin
        lk_match   = '0;
        srch_match = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            lk_match[i]   = tlb_e[i]
                          & (tlb_body[i][52] | (tlb_body[i][62:53] == lk_asid))
                          & vppn_eq(tlb_body[i][87:69], tlb_body[i][68:63], lk_vppn);
            srch_match[i] = tlb_e[i]
                          & (tlb_body[i][52] | (tlb_body[i][62:53] == req_asid))
                          & vppn_eq(tlb_body[i][87:69], tlb_body[i][68:63], req_vppn);
        end
    end

    // Priority encoders: scanning downwards lets the lowest index win.
    always_comb begin
        lk_hit   = 1'b0;
        lk_idx   = '0;
        srch_hit = 1'b0;
        srch_idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (lk_match[i]) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (srch_match[i]) begin
                srch_hit = 1'b1;
                srch_idx = IDX_W'(i);
            end
        end
    end

    // Lookup outputs; hits are hidden while a sweep is partway through the array.
    always_comb begin
        lk_index   = lk_idx;
        lk_ps      = tlb_body[lk_idx][68:63];
        lk_sel_odd = (lk_ps == 6'd21) ? lk_vppn[8] : lk_odd;
        lk_page    = lk_sel_odd ? tlb_body[lk_idx][25:0] : tlb_body[lk_idx][51:26];
        lk_found   = lk_hit & (state != ST_SWEEP);
    end

    // Invalidate condition for the entry currently under the sweep pointer.
    always_comb begin
        sw_body   = tlb_body[ptr];
        sw_g      = sw_body[52];
        sw_asid_m = (sw_body[62:53] == inv_asid);
        sw_va_m   = vppn_eq(sw_body[87:69], sw_body[68:63], inv_vppn);
        sw_clear  = 1'b0;
        case (inv_op)
            3'd0, 3'd1: sw_clear = 1'b1;
            3'd2:       sw_clear = sw_g;
            3'd3:       sw_clear = ~sw_g;
            3'd4:       sw_clear = ~sw_g & sw_asid_m;
            3'd5:       sw_clear = ~sw_g & sw_asid_m & sw_va_m;
            3'd6:       sw_clear = (sw_g | sw_asid_m) & sw_va_m;
            default:    sw_clear = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = (is_inv & ~inv_bad) ? ST_SWEEP : ST_DONE;
            end
            ST_SWEEP: begin
                if (sweep_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Galois LFSR (taps 16,14,13,11), free-running; low bits pick the FILL victim.
    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
    end

    // Sweep pointer and latched INVTLB operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            inv_op   <= '0;
            inv_asid <= '0;
            inv_vppn <= '0;
        end else if (start_sweep) begin
            ptr      <= '0;
            inv_op   <= req_invop[2:0];
            inv_asid <= req_asid;
            inv_vppn <= req_vppn;
        end else if (state == ST_SWEEP) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Valid bits: writes from WR/FILL, clears from the sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            tlb_e <= '0;
        end else if (wr_en) begin
            tlb_e[wr_idx] <= req_entry[88];
        end else if ((state == ST_SWEEP) && sw_clear) begin
            tlb_e[ptr] <= 1'b0;
        end
    end

    // Entry payload storage; meaningless while e=0, so left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) tlb_body[wr_idx] <= req_entry[87:0];
    end

    // Response fields, updated once per completed request and held until the next.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_err   <= 1'b0;
            resp_hit   <= 1'b0;
            resp_index <= '0;
            resp_entry <= '0;
        end else if (acc && !start_sweep) begin
            resp_err   <= req_bad;
            resp_hit   <= (req_op == OP_SRCH) & srch_hit;
            resp_index <= (req_op == OP_SRCH) ? srch_idx :
                          (req_op == OP_FILL) ? victim : '0;
            resp_entry <= ((req_op == OP_RD) && tlb_e[req_index]) ?
                          {1'b1, tlb_body[req_index]} : '0;
        end else if ((state == ST_SWEEP) && sweep_last) begin
            resp_err   <= 1'b0;
            resp_hit   <= 1'b0;
            resp_index <= '0;
            resp_entry <= '0;
        end
    end

endmodule

// File: tb/tb_tlb_maint_unit.sv
// Directed bench for tlb_maint_unit with a shadow entry table and LFSR reference.
module tb_tlb_maint_unit;

    localparam int          TLBNUM = 16;
    localparam int          IDX_W  = 4;
    localparam logic [15:0] SEED   = 16'hACE1;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [4:0]       req_invop;
    logic [IDX_W-1:0] req_index;
    logic [9:0]       req_asid;
    logic [18:0]      req_vppn;
    logic [88:0]      req_entry;
    logic             resp_valid, resp_err, resp_hit;
    logic [IDX_W-1:0] resp_index;
    logic [88:0]      resp_entry;
    logic [18:0]      lk_vppn;
    logic             lk_odd;
    logic [9:0]       lk_asid;
    logic             lk_found;
    logic [IDX_W-1:0] lk_index;
    logic [5:0]       lk_ps;
    logic [25:0]      lk_page;

    tlb_maint_unit #(.TLBNUM(TLBNUM), .IDX_W(IDX_W), .LFSR_SEED(SEED)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_invop(req_invop), .req_index(req_index), .req_asid(req_asid),
        .req_vppn(req_vppn), .req_entry(req_entry),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_hit(resp_hit),
        .resp_index(resp_index), .resp_entry(resp_entry),
        .lk_vppn(lk_vppn), .lk_odd(lk_odd), .lk_asid(lk_asid),
        .lk_found(lk_found), .lk_index(lk_index), .lk_ps(lk_ps), .lk_page(lk_page)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [88:0] shadow [TLBNUM];
    logic [15:0] m_lfsr;

    // Reference LFSR written bit by bit: feedback of bit 0 into positions 15,13,12,10.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] n;
        for (int b = 0; b < 15; b++) n[b] = v[b+1];
        n[15] = v[0];
        n[13] = v[14] ^ v[0];
        n[12] = v[13] ^ v[0];
        n[10] = v[11] ^ v[0];
        return n;
    endfunction

    always @(posedge clk) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic logic [88:0] mk_entry(input logic e, input logic [18:0] vppn,
                                             input logic [5:0] ps, input logic [9:0] asid,
                                             input logic g, input logic [25:0] p0,
                                             input logic [25:0] p1);
        return {e, vppn, ps, asid, g, p0, p1};
    endfunction

    task automatic check_val(input string tag, input logic [88:0] obs, input logic [88:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request from a negedge in an IDLE cycle; returns after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [4:0] invop, input logic [3:0] idx,
                         input logic [9:0] asid, input logic [18:0] vppn,
                         input logic [88:0] ent, output logic [3:0] victim);
        check_val("ready_before_req", req_ready, 1'b1);
        victim    = m_lfsr[3:0];
        req_op    = op;
        req_invop = invop;
        req_index = idx;
        req_asid  = asid;
        req_vppn  = vppn;
        req_entry = ent;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Non-sweep request: response in N+1, ready back in N+2.
    task automatic simple_req(input logic [2:0] op, input logic [4:0] invop, input logic [3:0] idx,
                              input logic [9:0] asid, input logic [18:0] vppn,
                              input logic [88:0] ent, output logic [3:0] victim);
        issue(op, invop, idx, asid, vppn, ent, victim);
        @(negedge clk);
        check_val("resp_valid_n1", resp_valid, 1'b1);
        check_val("ready_low_n1", req_ready, 1'b0);
        @(negedge clk);
        check_val("ready_high_n2", req_ready, 1'b1);
        check_val("resp_valid_low_n2", resp_valid, 1'b0);
    endtask

    task automatic do_wr(input logic [3:0] idx, input logic [88:0] ent);
        logic [3:0] v;
        simple_req(OP_WR, 5'd0, idx, 10'd0, 19'd0, ent, v);
        check_val("wr_err", resp_err, 1'b0);
        shadow[idx] = ent;
    endtask

    task automatic do_fill(input logic [88:0] ent, output logic [3:0] v);
        simple_req(OP_FILL, 5'd0, 4'd0, 10'd0, 19'd0, ent, v);
        check_val("fill_victim", resp_index, v);
        shadow[v] = ent;
    endtask

    task automatic do_rd(input logic [3:0] idx);
        logic [3:0]  v;
        logic [88:0] exp;
        simple_req(OP_RD, 5'd0, idx, 10'd0, 19'd0, 89'd0, v);
        exp = shadow[idx][88] ? shadow[idx] : 89'd0;
        check_val($sformatf("rd_entry_%0d", idx), resp_entry, exp);
    endtask

    task automatic do_srch(input logic [18:0] vppn, input logic [9:0] asid,
                           input logic exp_hit, input logic [3:0] exp_idx);
        logic [3:0] v;
        simple_req(OP_SRCH, 5'd0, 4'd0, asid, vppn, 89'd0, v);
        check_val("srch_err", resp_err, 1'b0);
        check_val("srch_hit", resp_hit, exp_hit);
        if (exp_hit) check_val("srch_index", resp_index, exp_idx);
    endtask

    initial begin
        logic [3:0]  v;
        logic [88:0] e5, e2, e9, e12, e7, e14;
        logic        got, saw_found, saw_valid;
        int          cyc;
        logic [15:0] cov_dut, cov_exp;

        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_invop = '0; req_index = '0;
        req_asid = '0; req_vppn = '0; req_entry = '0;
        lk_vppn = '0; lk_odd = 1'b0; lk_asid = '0;
        for (int i = 0; i < TLBNUM; i++) shadow[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check_val("rst_ready", req_ready, 1'b1);
        check_val("rst_resp_valid", resp_valid, 1'b0);
        check_val("rst_resp_err", resp_err, 1'b0);
        check_val("rst_resp_hit", resp_hit, 1'b0);
        check_val("rst_resp_index", resp_index, 4'd0);
        check_val("rst_resp_entry", resp_entry, 89'd0);
        lk_vppn = 19'h12345; lk_asid = 10'd1;
        #1 check_val("rst_lk_found", lk_found, 1'b0);
        do_srch(19'h12345, 10'd1, 1'b0, 4'd0);

        e5 = mk_entry(1'b1, 19'h12345, 6'd12, 10'd3, 1'b0, 26'h0ABCDEF, 26'h1357924);
        do_wr(4'd5, e5);
        lk_asid = 10'd3; lk_odd = 1'b1;
        #1;
        check_val("lk5_found", lk_found, 1'b1);
        check_val("lk5_index", lk_index, 4'd5);
        check_val("lk5_ps", lk_ps, 6'd12);
        check_val("lk5_page1", lk_page, 26'h1357924);
        lk_odd = 1'b0;
        #1 check_val("lk5_page0", lk_page, 26'h0ABCDEF);
        lk_asid = 10'd4;
        #1 check_val("lk5_asid_miss", lk_found, 1'b0);
        do_srch(19'h12345, 10'd3, 1'b1, 4'd5);
        do_srch(19'h12345, 10'd4, 1'b0, 4'd0);

        e2 = mk_entry(1'b1, 19'h0ABCD, 6'd12, 10'd7, 1'b1, 26'h111, 26'h222);
        e9 = mk_entry(1'b1, 19'h0ABCD, 6'd12, 10'd8, 1'b1, 26'h333, 26'h444);
        do_wr(4'd2, e2);
        do_wr(4'd9, e9);
        do_srch(19'h0ABCD, 10'h55, 1'b1, 4'd2);
        do_rd(4'd9);
        do_rd(4'd0);

        e12 = mk_entry(1'b1, 19'h7FE00, 6'd21, 10'd9, 1'b1, 26'h2AAAAAA, 26'h1555555);
        do_wr(4'd12, e12);
        lk_vppn = 19'h7FFFF; lk_asid = 10'd0; lk_odd = 1'b0;
        #1;
        check_val("lk12_found", lk_found, 1'b1);
        check_val("lk12_index", lk_index, 4'd12);
        check_val("lk12_page_va21", lk_page, 26'h1555555);
        lk_vppn = 19'h7FEFF; lk_odd = 1'b1;
        #1 check_val("lk12_page_va21_0", lk_page, 26'h2AAAAAA);
        do_srch(19'h7FE37, 10'd0, 1'b1, 4'd12);

        e7 = mk_entry(1'b0, 19'h11111, 6'd12, 10'd0, 1'b1, 26'h5, 26'h6);
        do_wr(4'd7, e7);
        do_srch(19'h11111, 10'd0, 1'b0, 4'd0);
        do_rd(4'd7);

        for (int k = 0; k < 4; k++)
            do_fill(mk_entry(1'b1, 19'h20000 + 19'(k), 6'd12, 10'h20 + 10'(k), k[0],
                             26'(k), 26'(k + 100)), v);

        e14 = mk_entry(1'b1, 19'h55555, 6'd12, 10'h3AA, 1'b1, 26'h0F0F0F0, 26'h0123456);
        do_wr(4'd14, e14);
        lk_vppn = 19'h55555; lk_asid = 10'd0; lk_odd = 1'b0;
        #1;
        check_val("lk14_found_pre", lk_found, 1'b1);
        check_val("lk14_index_pre", lk_index, 4'd14);

        // INVTLB op 3: completion 17 cycles after accept, lookup blanked meanwhile.
        issue(OP_INV, 5'd3, 4'd0, 10'd0, 19'd0, 89'd0, v);
        got = 1'b0; saw_found = 1'b0; cyc = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
                cyc = k;
            end else begin
                saw_found = saw_found | lk_found;
            end
        end
        check_val("inv3_latency", 32'(cyc), 32'd17);
        check_val("inv3_lk_blank", saw_found, 1'b0);
        check_val("inv3_err", resp_err, 1'b0);
        @(negedge clk);
        check_val("inv3_ready_after", req_ready, 1'b1);
        check_val("lk14_found_post", lk_found, 1'b1);
        for (int i = 0; i < TLBNUM; i++)
            if (!shadow[i][52]) shadow[i][88] = 1'b0;
        for (int i = 0; i < TLBNUM; i++) do_rd(4'(i));

        simple_req(OP_INV, 5'd7, 4'd0, 10'd0, 19'd0, 89'd0, v);
        check_val("inv7_err", resp_err, 1'b1);
        do_rd(4'd14);
        simple_req(3'd6, 5'd0, 4'd0, 10'd0, 19'd0, 89'd0, v);
        check_val("op6_err", resp_err, 1'b1);
        do_rd(4'd2);

        // Reset in the middle of an op-0 sweep.
        issue(OP_INV, 5'd0, 4'd0, 10'd0, 19'd0, 89'd0, v);
        repeat (5) @(negedge clk);
        check_val("mid_sweep_busy", req_ready, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("sweep_rst_ready", req_ready, 1'b1);
        check_val("sweep_rst_err", resp_err, 1'b0);
        saw_valid = resp_valid;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            saw_valid = saw_valid | resp_valid;
        end
        check_val("sweep_rst_no_resp", saw_valid, 1'b0);
        for (int i = 0; i < TLBNUM; i++) shadow[i] = '0;
        do_rd(4'd14);
        do_rd(4'd2);

        cov_dut = '0; cov_exp = '0;
        for (int k = 0; k < 100; k++) begin
            do_fill(mk_entry(1'b1, 19'(k), 6'd12, 10'd0, 1'b0, 26'(k), 26'(k)), v);
            cov_dut[resp_index] = 1'b1;
            cov_exp[v] = 1'b1;
        end
        check_val("fill_coverage", cov_dut, cov_exp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
